// File: rtl/altr_hps_bitsync_filt.sv
// ---------------------------------------------------------------------------
// altr_hps_bitsync_filt
//
// Parametrised multi-bit level synchronizer for quasi-static control/status
// levels crossing into the clk domain (resets-done, power-good, interrupt
// levels). Each bit is an independent channel:
//   data_in -> SYNCSTAGE-deep flop chain -> optional stability filter
//           -> data_out, plus 1-cycle rise/fall pulses on data_out edges.
// Not intended for buses that must stay coherent across bits.
//
// Parameters
//   DWIDTH     number of independent bit channels (1..64)
//   SYNCSTAGE  synchronizer flop stages per bit (2..8)
//   RESET_VAL  per-bit reset value for every flop of that channel
//   FILT_CNT   stability filter length in cycles (0..255), 0 = no filter
//
// Ports
//   clk       in   destination-domain clock
//   rst_n     in   async-assert, active-low reset (release pre-synchronized)
//   data_in   in   [DWIDTH] asynchronous levels from any source domain
//   data_out  out  [DWIDTH] synchronized (and filtered) levels
//   rise_pls  out  [DWIDTH] 1-cycle pulse when data_out[i] goes 0->1
//   fall_pls  out  [DWIDTH] 1-cycle pulse when data_out[i] goes 1->0
// ---------------------------------------------------------------------------
module altr_hps_bitsync_filt #(
  parameter int                DWIDTH    = 1,
  parameter int                SYNCSTAGE = 4,
  parameter logic [DWIDTH-1:0] RESET_VAL = {DWIDTH{1'b0}},
  parameter int                FILT_CNT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic [DWIDTH-1:0] rise_pls,
  output logic [DWIDTH-1:0] fall_pls
);

  // Counter only has to reach FILT_CNT-1; keep at least one bit so the
  // declaration stays legal when the filter is tiny or disabled.
  localparam int CNT_W = (FILT_CNT > 1) ? $clog2(FILT_CNT) : 1;

  // Reject illegal configurations at elaboration time.
  if (SYNCSTAGE < 2 || SYNCSTAGE > 8) begin : g_bad_syncstage
    $error("altr_hps_bitsync_filt: SYNCSTAGE must be 2..8");
  end
  if (DWIDTH < 1 || DWIDTH > 64) begin : g_bad_dwidth
    $error("altr_hps_bitsync_filt: DWIDTH must be 1..64");
  end
  if (FILT_CNT < 0 || FILT_CNT > 255) begin : g_bad_filt
    $error("altr_hps_bitsync_filt: FILT_CNT must be 0..255");
  end

  logic [DWIDTH-1:0] w_sync_q;
  logic [DWIDTH-1:0] w_data_out;
  logic [DWIDTH-1:0] r_out_d;

  for (genvar gi = 0; gi < DWIDTH; gi++) begin : g_ch
    // Plain shift chain, no logic between stages; stage 0 is the first
    // flop to sample the asynchronous input.
    logic [SYNCSTAGE-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_chain <= {SYNCSTAGE{RESET_VAL[gi]}};
      end else begin
        r_chain <= {r_chain[SYNCSTAGE-2:0], data_in[gi]};
      end
    end

    assign w_sync_q[gi] = r_chain[SYNCSTAGE-1];

    if (FILT_CNT == 0) begin : g_nofilt
      assign w_data_out[gi] = w_sync_q[gi];
    end else begin : g_filt
      logic             r_out_q;
      logic [CNT_W-1:0] r_cnt;

      // The output only follows sync_q after it has disagreed with the
      // output for FILT_CNT consecutive edges; any return to agreement
      // restarts the count from zero.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_out_q <= RESET_VAL[gi];
          r_cnt   <= '0;
        end else if (w_sync_q[gi] == r_out_q) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_W'(FILT_CNT - 1)) begin
          r_out_q <= w_sync_q[gi];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign w_data_out[gi] = r_out_q;
    end
  end

  // Delayed copy for edge detection. It resets to the same value as the
  // output, so neither reset entry nor exit produces a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_d <= RESET_VAL;
    end else begin
      r_out_d <= w_data_out;
    end
  end

  assign data_out = w_data_out;
  assign rise_pls = w_data_out & ~r_out_d;
  assign fall_pls = ~w_data_out & r_out_d;

endmodule
